lockstep_alu_chk: RTL and testbench
===================================

# lockstep_alu_chk

Parametrised dual-lane lockstep ALU checker, the next generation of the 4-bit dual-ALU/XOR compare block driven from the user-area IOs. Two independent WIDTH-bit ALU lanes compute in parallel and register their results. A compare stage flags bitwise and carry divergence. Mismatch history feeds a saturating error counter, a consecutive-mismatch tracker and a sticky fault state machine, with optional fault injection for self-test.

## Interface
- WIDTH, 4: operand/result width per lane (≥2).
- ERR_THRESH, 3: consecutive mismatches that trip ALARM (≥1).
- CNT_W, 8: width of the total error counter.

- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- en  input  1  block enable; low forces IDLE.
- valid_i  input  1  operand strobe, sampled when en=1.
- a0, b0  input  WIDTH  lane 0 operands.
- sel0  input  2  lane 0 op.
- a1, b1  input  WIDTH  lane 1 operands.
- sel1  input  2  lane 1 op.
- inject_i  input  1  when high with valid_i, invert bit 0 of lane 1 result before register/compare.
- clear_i  input  1  clears counters and leaves ALARM.
- out0, out1  output  WIDTH  registered lane results.
- carry0, carry1  output  1  registered lane carries.
- valid_o  output  1  one-cycle result strobe.
- diff_o  output  WIDTH  out0 ^ out1 (registered).
- mismatch_o  output  1  (diff≠0) or (carry0≠carry1), registered with valid_o.
- err_cnt_o  output  CNT_W  saturating total mismatch count.
- fault_o  output  1  high in ALARM.
- state_o  output  2  00 IDLE, 01 RUN, 10 ALARM.

## Operation
- Op encoding (per lane): 00 ADD a+b, carry = bit WIDTH of sum; 01 SUB a−b (= a+~b+1), carry = 1 iff a≥b unsigned; 10 AND, carry 0; 11 XOR, carry 0. Results truncated to WIDTH (modulo 2^WIDTH).
- Accepted sample = valid_i & en & state≠IDLE-entry cycle (see transitions). On accept, lanes, diff_o, mismatch_o register; valid_o=1 next cycle only.
- Without accept, out*/carry*/diff_o/mismatch_o hold; valid_o=0.
- Counters on each accepted sample: mismatch → err_cnt +1 (saturate at 2^CNT_W−1), consec +1 (saturate at ERR_THRESH); match → consec = 0, err_cnt holds.
- FSM:
  - IDLE → RUN when en=1 (one cycle; valid_i in that cycle ignored).
  - RUN → IDLE when en=0.
  - RUN → ALARM on the edge where consec reaches ERR_THRESH.
  - ALARM → RUN only on clear_i (en=1), or → IDLE on clear_i with en=0.
  - ALARM ignores en; lanes keep computing and err_cnt keeps counting while en=1.
- clear_i: err_cnt and consec → 0 on that edge. Takes priority over a same-cycle mismatch (not counted); mismatch_o/diff_o still update.
- en=0: counters hold, no accepts.

## Timing
- Reset (rst_n=0 at edge): all outputs 0, state IDLE, consec 0. Reset mid-operation discards any in-flight result; valid_o=0 the following cycle.
- Latency: operands sampled at edge N → out*/diff_o/mismatch_o/valid_o/err_cnt_o valid after edge N; fault_o/state_o updated at the same edge N.
- Back-to-back valid_i every cycle supported; throughput 1 sample/clock.
- No backpressure; valid_o is not held.

## Test plan
- Reset: drive rst_n=0 one edge → all outputs 0, state_o=00; en=1 → state_o=01 after one edge.
- ADD agree (WIDTH=4): a=9,b=8 both lanes → out0=out1=1, carry0=carry1=1, diff_o=0, mismatch_o=0, valid_o pulse one cycle.
- SUB/logic: a=3,b=5 SUB → out=0xE, carry=0; a=0xC,b=0xA AND → 0x8; XOR → 0x6; carries 0.
- Lane divergence: lane0 2+3, lane1 2+2 → out0=5, out1=4, diff_o=0x1, mismatch_o=1, err_cnt_o=1, state RUN.
- Injection/ALARM: three consecutive valid_i with inject_i=1, matching operands → fault_o rises on the third result edge, state_o=10. A matching 4th sample keeps ALARM. clear_i → RUN, err_cnt_o=0. A mismatch coincident with clear_i is not counted.
- Saturation: CNT_W=2, ERR_THRESH=8, five mismatches → err_cnt_o stays 3; a match between mismatches resets consec and leaves err_cnt unchanged.

Source files
------------

// File: rtl/lockstep_alu_chk_if.sv
// Bus bundle for the lockstep ALU checker: operand strobe, both lane
// operand sets, control strobes and all registered result/status outputs.
//
// Handshake: valid_i is a one-cycle operand strobe with no ready/backpressure;
// a sample is taken on the rising edge when valid_i=1, en=1 and the checker
// is not in its IDLE-entry cycle. valid_o pulses for exactly one cycle after
// each accepted sample and is never held.
interface lockstep_alu_chk_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic             valid_i;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [1:0]       sel0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [1:0]       sel1;
    logic             inject_i;
    logic             clear_i;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic             carry0;
    logic             carry1;
    logic             valid_o;
    logic [WIDTH-1:0] diff_o;
    logic             mismatch_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic             fault_o;
    logic [1:0]       state_o;

    modport master (
        output en, valid_i, a0, b0, sel0, a1, b1, sel1, inject_i, clear_i,
        input  out0, out1, carry0, carry1, valid_o, diff_o, mismatch_o,
               err_cnt_o, fault_o, state_o
    );

    modport slave (
        input  en, valid_i, a0, b0, sel0, a1, b1, sel1, inject_i, clear_i,
        output out0, out1, carry0, carry1, valid_o, diff_o, mismatch_o,
               err_cnt_o, fault_o, state_o
    );
endinterface

// File: rtl/lockstep_alu_chk.sv
// Dual-lane lockstep ALU checker. Two WIDTH-bit ALU lanes compute in
// parallel; a compare stage flags result/carry divergence, which feeds a
// saturating error counter, a consecutive-mismatch tracker and a sticky
// IDLE/RUN/ALARM state machine. Lane 1 bit 0 can be inverted for self-test.
module lockstep_alu_chk #(
    parameter int WIDTH      = 4,
    parameter int ERR_THRESH = 3,
    parameter int CNT_W      = 8
) (
    input logic               clk,
    input logic               rst_n,
    lockstep_alu_chk_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        ALARM = 2'b10
    } state_t;

    localparam int CONS_W = $clog2(ERR_THRESH + 1);
    localparam logic [CONS_W-1:0] THRESH = CONS_W'(ERR_THRESH);

    state_t             state, state_next;
    logic [CONS_W-1:0]  consec, consec_next;
    logic [CNT_W-1:0]   err_cnt, err_next;

    logic [WIDTH-1:0]   out0_q, out1_q, diff_q;
    logic               carry0_q, carry1_q, mis_q, valid_q;

    logic [WIDTH:0]     res0, res1;
    logic [WIDTH-1:0]   diff_next;
    logic               mis_next;
    logic               accept;
    logic               trip;

    // Carry is returned in bit WIDTH; SUB carry is the no-borrow flag (a >= b).
    function automatic logic [WIDTH:0] alu(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [1:0]       sel);
        logic [WIDTH:0] r;
        case (sel)
            2'b00:   r = {1'b0, a} + {1'b0, b};
            2'b01:   r = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
            2'b10:   r = {1'b0, a & b};
            default: r = {1'b0, a ^ b};
        endcase
        return r;
    endfunction

    // Lane evaluation, fault injection on lane 1 bit 0, and divergence compare.
    always_comb begin
        res0      = alu(bus.a0, bus.b0, bus.sel0);
        res1      = alu(bus.a1, bus.b1, bus.sel1);
        res1[0]   = res1[0] ^ (bus.inject_i & bus.valid_i);
        diff_next = res0[WIDTH-1:0] ^ res1[WIDTH-1:0];
        mis_next  = (|diff_next) | (res0[WIDTH] ^ res1[WIDTH]);
        accept    = bus.valid_i & bus.en & (state != IDLE);
    end

    // Counter update: clear wins over a same-cycle mismatch; both saturate.
    always_comb begin
        consec_next = consec;
        err_next    = err_cnt;
        trip        = 1'b0;
        if (bus.clear_i) begin
            consec_next = '0;
            err_next    = '0;
        end else if (accept) begin
            if (mis_next) begin
                if (consec < THRESH) consec_next = consec + 1'b1;
                if (err_cnt != {CNT_W{1'b1}}) err_next = err_cnt + 1'b1;
                trip = (consec_next == THRESH);
            end else begin
                consec_next = '0;
            end
        end
    end

    // Next-state logic; ALARM is sticky until clear_i regardless of en.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.en) state_next = RUN;
            RUN: begin
                if (!bus.en)   state_next = IDLE;
                else if (trip) state_next = ALARM;
            end
            ALARM:   if (bus.clear_i) state_next = bus.en ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            consec  <= '0;
            err_cnt <= '0;
        end else begin
            state   <= state_next;
            consec  <= consec_next;
            err_cnt <= err_next;
        end
    end

    // Result registers: load on accept, otherwise hold; valid_o is a pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out0_q   <= '0;
            out1_q   <= '0;
            carry0_q <= 1'b0;
            carry1_q <= 1'b0;
            diff_q   <= '0;
            mis_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                out0_q   <= res0[WIDTH-1:0];
                out1_q   <= res1[WIDTH-1:0];
                carry0_q <= res0[WIDTH];
                carry1_q <= res1[WIDTH];
                diff_q   <= diff_next;
                mis_q    <= mis_next;
            end
        end
    end

    assign bus.out0       = out0_q;
    assign bus.out1       = out1_q;
    assign bus.carry0     = carry0_q;
    assign bus.carry1     = carry1_q;
    assign bus.diff_o     = diff_q;
    assign bus.mismatch_o = mis_q;
    assign bus.valid_o    = valid_q;
    assign bus.err_cnt_o  = err_cnt;
    assign bus.fault_o    = (state == ALARM);
    assign bus.state_o    = state;
endmodule

// File: tb/tb_lockstep_alu_chk.sv
// Directed bench for lockstep_alu_chk: a table of single-sample vectors plus
// hand-written sequences for reset, ALARM/clear and counter saturation.
module tb_lockstep_alu_chk;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    lockstep_alu_chk_if #(.WIDTH(4), .CNT_W(8)) bus ();
    lockstep_alu_chk_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

    lockstep_alu_chk #(.WIDTH(4), .ERR_THRESH(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    lockstep_alu_chk #(.WIDTH(4), .ERR_THRESH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    // Clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a0, b0;
        logic [1:0] sel0;
        logic [3:0] a1, b1;
        logic [1:0] sel1;
        logic       inj;
        logic [3:0] out0, out1;
        logic       c0, c1;
        logic [3:0] diff;
        logic       mis;
        logic [7:0] err;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[9];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver: set main-bus inputs, cross one edge, sample 1 time unit later.
    task automatic apply(input logic en, input logic valid, input logic [3:0] a0,
                         input logic [3:0] b0, input logic [1:0] sel0,
                         input logic [3:0] a1, input logic [3:0] b1,
                         input logic [1:0] sel1, input logic inj, input logic clr);
        bus.en = en; bus.valid_i = valid;
        bus.a0 = a0; bus.b0 = b0; bus.sel0 = sel0;
        bus.a1 = a1; bus.b1 = b1; bus.sel1 = sel1;
        bus.inject_i = inj; bus.clear_i = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic apply2(input logic en, input logic valid, input logic inj);
        bus2.en = en; bus2.valid_i = valid;
        bus2.a0 = 4'd1; bus2.b0 = 4'd1; bus2.sel0 = 2'b00;
        bus2.a1 = 4'd1; bus2.b1 = 4'd1; bus2.sel1 = 2'b00;
        bus2.inject_i = inj; bus2.clear_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_err2[6];

        //            a0    b0    s0     a1    b1    s1   inj  out0  out1 c0 c1 diff mis err  st
        vecs[0] = '{4'd9, 4'd8, 2'b00, 4'd9, 4'd8, 2'b00, 0, 4'h1, 4'h1, 1, 1, 4'h0, 0, 8'd0, 2'b01};
        vecs[1] = '{4'd3, 4'd5, 2'b01, 4'd3, 4'd5, 2'b01, 0, 4'hE, 4'hE, 0, 0, 4'h0, 0, 8'd0, 2'b01};
        vecs[2] = '{4'hC, 4'hA, 2'b10, 4'hC, 4'hA, 2'b10, 0, 4'h8, 4'h8, 0, 0, 4'h0, 0, 8'd0, 2'b01};
        vecs[3] = '{4'hC, 4'hA, 2'b11, 4'hC, 4'hA, 2'b11, 0, 4'h6, 4'h6, 0, 0, 4'h0, 0, 8'd0, 2'b01};
        vecs[4] = '{4'd5, 4'd3, 2'b01, 4'd5, 4'd3, 2'b01, 0, 4'h2, 4'h2, 1, 1, 4'h0, 0, 8'd0, 2'b01};
        vecs[5] = '{4'd2, 4'd3, 2'b00, 4'd2, 4'd2, 2'b00, 0, 4'h5, 4'h4, 0, 0, 4'h1, 1, 8'd1, 2'b01};
        vecs[6] = '{4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 2'b00, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 8'd1, 2'b01};
        vecs[7] = '{4'd8, 4'd8, 2'b00, 4'd0, 4'd0, 2'b11, 0, 4'h0, 4'h0, 1, 0, 4'h0, 1, 8'd2, 2'b01};
        vecs[8] = '{4'hF, 4'h1, 2'b00, 4'd0, 4'd0, 2'b01, 0, 4'h0, 4'h0, 1, 1, 4'h0, 0, 8'd2, 2'b01};
        exp_err2 = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};

        bus2.en = 1'b0; bus2.valid_i = 1'b0; bus2.inject_i = 1'b0; bus2.clear_i = 1'b0;
        bus2.a0 = '0; bus2.b0 = '0; bus2.sel0 = '0; bus2.a1 = '0; bus2.b1 = '0; bus2.sel1 = '0;

        // Reset: everything zero, IDLE.
        rst_n = 1'b0;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_out0", bus.out0, 0);
        check("rst_out1", bus.out1, 0);
        check("rst_carry0", bus.carry0, 0);
        check("rst_carry1", bus.carry1, 0);
        check("rst_valid", bus.valid_o, 0);
        check("rst_diff", bus.diff_o, 0);
        check("rst_mis", bus.mismatch_o, 0);
        check("rst_err", bus.err_cnt_o, 0);
        check("rst_fault", bus.fault_o, 0);
        check("rst_state", bus.state_o, 2'b00);

        // IDLE-entry cycle: valid_i is ignored.
        rst_n = 1'b1;
        apply(1, 1, 4'd9, 4'd8, 2'b00, 4'd9, 4'd8, 2'b00, 0, 0);
        check("entry_state", bus.state_o, 2'b01);
        check("entry_valid", bus.valid_o, 0);
        check("entry_out0", bus.out0, 0);

        // Table vectors, each followed by an idle cycle checking pulse/hold.
        for (int i = 0; i < 9; i++) begin
            apply(1, 1, vecs[i].a0, vecs[i].b0, vecs[i].sel0,
                  vecs[i].a1, vecs[i].b1, vecs[i].sel1, vecs[i].inj, 0);
            check($sformatf("v%0d_out0", i), bus.out0, vecs[i].out0);
            check($sformatf("v%0d_out1", i), bus.out1, vecs[i].out1);
            check($sformatf("v%0d_c0", i), bus.carry0, vecs[i].c0);
            check($sformatf("v%0d_c1", i), bus.carry1, vecs[i].c1);
            check($sformatf("v%0d_diff", i), bus.diff_o, vecs[i].diff);
            check($sformatf("v%0d_mis", i), bus.mismatch_o, vecs[i].mis);
            check($sformatf("v%0d_err", i), bus.err_cnt_o, vecs[i].err);
            check($sformatf("v%0d_state", i), bus.state_o, vecs[i].st);
            check($sformatf("v%0d_valid", i), bus.valid_o, 1);
            apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            check($sformatf("v%0d_valid_drop", i), bus.valid_o, 0);
            check($sformatf("v%0d_hold_out0", i), bus.out0, vecs[i].out0);
            check($sformatf("v%0d_hold_mis", i), bus.mismatch_o, vecs[i].mis);
        end

        // Three injected mismatches trip ALARM on the third (err starts at 2).
        apply(1, 1, 4'd1, 4'd1, 2'b00, 4'd1, 4'd1, 2'b00, 1, 0);
        check("inj1_out1", bus.out1, 4'h3);
        check("inj1_diff", bus.diff_o, 4'h1);
        check("inj1_err", bus.err_cnt_o, 3);
        check("inj1_state", bus.state_o, 2'b01);
        apply(1, 1, 4'd1, 4'd1, 2'b00, 4'd1, 4'd1, 2'b00, 1, 0);
        check("inj2_err", bus.err_cnt_o, 4);
        check("inj2_fault", bus.fault_o, 0);
        apply(1, 1, 4'd1, 4'd1, 2'b00, 4'd1, 4'd1, 2'b00, 1, 0);
        check("inj3_err", bus.err_cnt_o, 5);
        check("inj3_fault", bus.fault_o, 1);
        check("inj3_state", bus.state_o, 2'b10);
        apply(1, 1, 4'd1, 4'd1, 2'b00, 4'd1, 4'd1, 2'b00, 0, 0);
        check("alarm_match_state", bus.state_o, 2'b10);
        check("alarm_match_mis", bus.mismatch_o, 0);
        check("alarm_match_err", bus.err_cnt_o, 5);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("alarm_en0_state", bus.state_o, 2'b10);
        // Clear with a coincident mismatch: not counted, result still updates.
        apply(1, 1, 4'd1, 4'd1, 2'b00, 4'd1, 4'd1, 2'b00, 1, 1);
        check("clear_state", bus.state_o, 2'b01);
        check("clear_err", bus.err_cnt_o, 0);
        check("clear_mis", bus.mismatch_o, 1);
        check("clear_fault", bus.fault_o, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("post_clear_err", bus.err_cnt_o, 0);

        // RUN -> IDLE on en=0, then reset mid-operation drops the sample.
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("en0_state", bus.state_o, 2'b00);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reen_state", bus.state_o, 2'b01);
        rst_n = 1'b0;
        apply(1, 1, 4'd2, 4'd3, 2'b00, 4'd2, 4'd2, 2'b00, 0, 0);
        check("midrst_valid", bus.valid_o, 0);
        check("midrst_out1", bus.out1, 0);
        check("midrst_state", bus.state_o, 2'b00);
        rst_n = 1'b1;

        // Saturation on the CNT_W=2 / ERR_THRESH=8 instance.
        apply2(1, 0, 0);
        check("sat_entry_state", bus2.state_o, 2'b01);
        for (int i = 0; i < 6; i++) begin
            apply2(1, 1, (i != 2));
            check($sformatf("sat%0d_err", i), bus2.err_cnt_o, exp_err2[i]);
            check($sformatf("sat%0d_state", i), bus2.state_o, 2'b01);
        end

        // Report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
